// File: rtl/mux_sel_sequencer_pkg.sv
// Shared encodings for the mux select sequencer: FSM states and the last select position.
package mux_sel_sequencer_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  localparam logic [1:0] SEL_LAST = 2'd3;
endpackage

// File: rtl/mux_sel_sequencer_dwell_counter.sv
// Dwell counter for one select position; tick is registered and high while count == DWELL-1.
module dwell_counter #(
  parameter int DWELL = 1,
  parameter int CNT_W = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic en,
  output logic tick
);
  localparam int LAST_I = (DWELL < 1) ? 0 : DWELL - 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_I);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;

  assign count_inc = count + CNT_W'(1);

  // tick is computed from the value count will hold next cycle so it lines up with count itself
  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (clear) begin
      count <= '0;
      tick  <= (LAST == '0);
    end else if (en) begin
      count <= count_inc;
      tick  <= (count_inc == LAST);
    end else begin
      tick  <= 1'b0;
    end
  end
endmodule

// File: rtl/mux_sel_sequencer.sv
// Drives a latched word onto a 4:1 mux, steps the select 0..3 with a dwell, and reassembles Y into Q.
module mux_sel_sequencer
  import mux_sel_sequencer_pkg::*;
#(
  parameter int DWELL = 1,
  parameter int CNT_W = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [3:0] DATA,
  input  logic       Y,
  output logic [1:0] S,
  output logic [3:0] I,
  output logic       BUSY,
  output logic       STEP,
  output logic [3:0] Q,
  output logic       DONE,
  output logic       MISMATCH
);
  state_t     state, nxt;
  logic       tick, clear, en, accept;
  logic [1:0] s_nxt;
  logic [3:0] q_nxt;

  dwell_counter #(.DWELL(DWELL), .CNT_W(CNT_W)) u_dwell (
    .CLK  (CLK),
    .RST  (RST),
    .clear(clear),
    .en   (en),
    .tick (tick)
  );

  assign STEP = tick;

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt    = state;
    clear  = 1'b0;
    en     = 1'b0;
    accept = 1'b0;
    s_nxt  = S;
    q_nxt  = Q;
    case (state)
      ST_IDLE: begin
        s_nxt = 2'd0;
        if (START) begin
          accept = 1'b1;
          clear  = 1'b1;
          q_nxt  = 4'd0;
          nxt    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (tick) begin
          q_nxt[S] = Y;
          if (S == SEL_LAST) begin
            nxt = ST_FINISH;
          end else begin
            s_nxt = S + 2'd1;
            clear = 1'b1;
          end
        end else begin
          en = 1'b1;
        end
      end
      ST_FINISH: begin
        s_nxt = 2'd0;
        nxt   = ST_IDLE;
      end
      default: begin
        s_nxt = 2'd0;
        nxt   = ST_IDLE;
      end
    endcase
  end

  // Flags are loaded from the next-state decode so they are valid in the cycle they describe
  always_ff @(posedge CLK) begin
    if (RST) begin
      S        <= 2'd0;
      I        <= 4'd0;
      Q        <= 4'd0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      MISMATCH <= 1'b0;
    end else begin
      S        <= s_nxt;
      Q        <= q_nxt;
      if (accept) I <= DATA;
      BUSY     <= (nxt != ST_IDLE);
      DONE     <= (nxt == ST_FINISH);
      MISMATCH <= (nxt == ST_FINISH) && (q_nxt != I);
    end
  end
endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed bench: two sequencers (DWELL=1 and DWELL=3) each looped through a 4:1 mux model.
module tb_mux_sel_sequencer;
  logic       clk = 1'b0;
  logic       rst, start, fault;
  logic [3:0] data;

  logic [1:0] d1_s, d3_s;
  logic [3:0] d1_i, d3_i, d1_q, d3_q;
  logic       d1_busy, d1_step, d1_done, d1_mm, d1_y;
  logic       d3_busy, d3_step, d3_done, d3_mm, d3_y;

  int n_chk = 0;
  int n_err = 0;

  // Expected S / STEP per cycle after the START edge (index 0 = cycle t+1)
  localparam logic [1:0] E_S1  [14] = '{0,1,2,3,3,0,0,0,0,0,0,0,0,0};
  localparam logic       E_ST1 [14] = '{1,1,1,1,0,0,0,0,0,0,0,0,0,0};
  localparam logic [1:0] E_S3  [14] = '{0,0,0,1,1,1,2,2,2,3,3,3,3,0};
  localparam logic       E_ST3 [14] = '{0,0,1,0,0,1,0,0,1,0,0,1,0,0};

  always #5 clk = ~clk;

  // 4:1 mux model; fault forces Y low
  assign d1_y = fault ? 1'b0 : d1_i[d1_s];
  assign d3_y = fault ? 1'b0 : d3_i[d3_s];

  mux_sel_sequencer #(.DWELL(1), .CNT_W(8)) u_d1 (
    .CLK(clk), .RST(rst), .START(start), .DATA(data), .Y(d1_y),
    .S(d1_s), .I(d1_i), .BUSY(d1_busy), .STEP(d1_step), .Q(d1_q),
    .DONE(d1_done), .MISMATCH(d1_mm)
  );

  mux_sel_sequencer #(.DWELL(3), .CNT_W(8)) u_d3 (
    .CLK(clk), .RST(rst), .START(start), .DATA(data), .Y(d3_y),
    .S(d3_s), .I(d3_i), .BUSY(d3_busy), .STEP(d3_step), .Q(d3_q),
    .DONE(d3_done), .MISMATCH(d3_mm)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_d1"}, {d1_s, d1_i, d1_q, d1_busy, d1_step, d1_done, d1_mm}, 16'd0);
    chk({tag, "_d3"}, {d3_s, d3_i, d3_q, d3_busy, d3_step, d3_done, d3_mm}, 16'd0);
  endtask

  // Pulse START with d, then follow both DUTs for 14 cycles against the tables
  task automatic run_scan(input logic [3:0] d, input logic [3:0] eq, input logic em, input bit repulse);
    data  = d;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      chk("s1",    d1_s,    E_S1[c-1]);
      chk("step1", d1_step, E_ST1[c-1]);
      chk("done1", d1_done, c == 5);
      chk("busy1", d1_busy, c <= 5);
      chk("s3",    d3_s,    E_S3[c-1]);
      chk("step3", d3_step, E_ST3[c-1]);
      chk("done3", d3_done, c == 13);
      chk("busy3", d3_busy, c <= 13);
      if (c == 5)  begin chk("q1", d1_q, eq); chk("mm1", d1_mm, em); chk("i1", d1_i, d); end
      if (c == 13) begin chk("q3", d3_q, eq); chk("mm3", d3_mm, em); chk("i3", d3_i, d); end
      if (c == 14) chk("q3_hold", d3_q, eq);
      if (repulse && c == 3) begin
        start = 1'b1;
        data  = 4'b0001;
      end else begin
        start = 1'b0;
      end
      step();
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    fault = 1'b0;
    data  = 4'd0;
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk_reset_state("idle");
      step();
    end

    run_scan(4'b1010, 4'b1010, 1'b0, 1'b0);
    run_scan(4'b0110, 4'b0110, 1'b0, 1'b0);

    fault = 1'b1;
    run_scan(4'b1111, 4'b0000, 1'b1, 1'b0);
    fault = 1'b0;

    run_scan(4'b1000, 4'b1000, 1'b0, 1'b1);

    // START held high: one IDLE cycle between back-to-back scans
    data  = 4'b0101;
    start = 1'b1;
    step();
    for (int c = 1; c <= 15; c++) begin
      if (c == 5)  chk("hold_done1", d1_done, 1'b1);
      if (c == 6)  chk("hold_idle1", {d1_busy, d1_s}, 3'b000);
      if (c == 7)  chk("hold_re1", {d1_busy, d1_step, d1_s}, 4'b1100);
      if (c == 13) chk("hold_done3", {d3_done, d3_q}, 5'b10101);
      if (c == 14) chk("hold_idle3", d3_busy, 1'b0);
      if (c == 15) chk("hold_re3", {d3_busy, d3_step, d3_s}, 4'b1000);
      step();
    end
    start = 1'b0;
    for (int k = 0; k < 20; k++) step();
    chk("flush_idle", {d1_busy, d3_busy}, 2'b00);

    // RST on the second STEP of a DWELL=3 scan
    data  = 4'b1100;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 6; c++) step();
    chk("rst_at_step2", {d3_step, d3_s}, 3'b101);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_state("after_rst");
    for (int k = 0; k < 15; k++) begin
      chk("no_done", {d1_done, d3_done, d3_busy}, 3'b000);
      step();
    end

    run_scan(4'b0011, 4'b0011, 1'b0, 1'b0);

    // RST and START together: RST wins
    data  = 4'b1001;
    start = 1'b1;
    rst   = 1'b1;
    step();
    start = 1'b0;
    rst   = 1'b0;
    chk_reset_state("rst_start");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mux_sel_sequencer.md
Name: mux_sel_sequencer

Overview:
- Upstream control stage for the 4:1 mux (`S[1:0]`, `I[3:0]` -> `Y`).
- Latches a 4-bit word, drives it onto the mux data inputs, then steps the select through 0..3, holding each position for a programmable dwell.
- Samples the mux output `Y` at each position and reassembles it into `Q`. This gives a 4-bit serial scan plus a loopback self-check of the mux.

Parameters:
- `DWELL`, 1, cycles each select value is held (legal 1..255; 0 is treated as 1).
- `CNT_W`, 8, width of the dwell counter (must hold `DWELL-1`).

Ports:
- `CLK  in  1`  rising-edge clock
- `RST  in  1`  synchronous, active-high reset
- `START  in  1`  begin a scan; sampled only in IDLE
- `DATA  in  4`  word latched on accepted START
- `Y  in  1`  mux output (combinational from `S`/`I`)
- `S  out  2`  mux select
- `I  out  4`  latched word, drives mux data inputs
- `BUSY  out  1`  high in SCAN and FINISH
- `STEP  out  1`  one-cycle strobe: `Y` sampled this cycle at select `S`
- `Q  out  4`  reassembled word; `Q[k]` is the `Y` sampled at `S=k`
- `DONE  out  1`  one-cycle pulse at end of scan
- `MISMATCH  out  1`  valid with DONE: high if `Q != I`

Behaviour:
- Reset (synchronous, active-high, clocked on `CLK`):
  - state = IDLE.
  - `S`=0, `I`=0, `Q`=0, dwell count=0.
  - `BUSY`, `STEP`, `DONE`, `MISMATCH` all 0.
- All outputs are registered. `Y` is assumed combinational from the registered `S` and `I`.
- IDLE:
  - `BUSY`=0, `S`=0.
  - START=1 at edge t: latch `I`<=`DATA`, `Q`<=0, `S`<=0, count<=0, state<=SCAN (`BUSY`=1 from t+1).
- SCAN:
  - Each cycle, count increments.
  - When count==`DWELL`-1:
    - `Q[S]`<=`Y` and `STEP`=1 that cycle.
    - If `S`==3: state<=FINISH.
    - Else: `S`<=`S`+1, count<=0.
  - `S` never wraps inside SCAN.
  - `S` and `I` are stable for exactly `DWELL` cycles per position.
- FINISH (one cycle):
  - `DONE`=1, `MISMATCH`=(`Q`!=`I`), `BUSY`=1.
  - Next state IDLE, `S`<=0.
  - `Q` and `I` hold until the next accepted START.
- Latency: START edge -> DONE asserted 4*`DWELL`+1 cycles later. Next START is accepted one cycle after DONE.
- START while BUSY is ignored; `DATA` changes while BUSY are ignored.
- START held high continuously: back-to-back scans with one IDLE cycle between them.
- RST mid-scan: abort; all registers return to reset values on that edge; no DONE pulse.
- RST and START in the same cycle: RST wins.
- `DWELL`=1: STEP is high every SCAN cycle; `S` advances each cycle.

Decomposition:
- Shared include file:
  - state encodings `ST_IDLE`=2'd0, `ST_SCAN`=2'd1, `ST_FINISH`=2'd2.
  - `SEL_LAST`=2'd3.
- One natural sub-module: `dwell_counter`.
  - Inputs: `CLK`, `RST`, `clear`, `en`.
  - Output: `tick` when count==`DWELL`-1.
  - Parameterised by `DWELL` and `CNT_W`.
- The bench instantiates `MUX_4_1_if` driven by `S`/`I`, with `Y` fed back.

Test Plan:
- Reset then idle 10 cycles -> `S`=0, `I`=0, `Q`=0, `BUSY`/`STEP`/`DONE`/`MISMATCH`=0 throughout.
- `DWELL`=1, `DATA`=4'b1010, START 1 cycle, correct mux -> `S` 0,1,2,3 on cycles t+1..t+4; STEP high t+1..t+4; DONE at t+5; `Q`=4'b1010; `MISMATCH`=0.
- `DWELL`=3, `DATA`=4'b0110 -> each `S` held 3 cycles; 4 STEP pulses 3 cycles apart; DONE at t+13; `Q`=4'b0110.
- Faulty mux model (`Y` forced 0), `DATA`=4'b1111 -> `Q`=4'b0000; `MISMATCH`=1 with DONE.
- START re-pulsed with `DATA`=4'b0001 mid-scan of 4'b1000 -> ignored; `Q`=4'b1000 at DONE. START held high -> next scan begins one cycle after DONE.
- RST at the second STEP of a scan -> next cycle all outputs at reset values, no DONE. New START then completes normally.
